// File: rtl/yari_muldiv_pkg.sv
// Shared definitions for the sequential multiplier and divider: state encodings,
// operand width, divide-by-zero quotient and HI/LO result field offsets.
package yari_muldiv_pkg;

  localparam int MD_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [MD_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

  localparam int RES_HI_LSB = MD_W;
  localparam int RES_LO_LSB = 0;

endpackage

// File: rtl/divider.sv
// Iterative restoring divider for DIV/DIVU, one quotient bit per cycle, result {rem, quot}.
// Define DIV_EARLY_EXIT_EN to retire 8 leading-zero quotient bits per cycle when possible.
module divider
  import yari_muldiv_pkg::*;
#(
  parameter int W = MD_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   op1,
  input  logic [W-1:0]   op2,
  input  logic           is_signed,
  input  logic           go,
  output logic [2*W-1:0] res,
  output logic           hold
);

  localparam int CW = $clog2(W);

  function automatic logic [W-1:0] neg_if(input logic [W-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [W-1:0] abs_val(input logic [W-1:0] v, input logic sgn);
    return neg_if(v, sgn & v[W-1]);
  endfunction

  logic [1:0]     state_q, state_d;
  logic [W-1:0]   r_q, r_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   d_q, d_d;
  logic [CW-1:0]  count_q, count_d;
  logic           neg_quot_q, neg_quot_d;
  logic           neg_rem_q, neg_rem_d;
  logic [2*W-1:0] res_q, res_d;
  logic           valid_q, valid_d;

  logic [W:0]     r_sh;
  logic           ge;
  logic [W-1:0]   r_step, q_step;
  logic [CW-1:0]  cnt_step;
  logic           last_step;

  // The shifted partial remainder can exceed W bits, hence the W+1 compare.
  always_comb begin
    r_sh      = {r_q, q_q[W-1]};
    ge        = (r_sh >= {1'b0, d_q});
    r_step    = ge ? (r_sh[W-1:0] - d_q) : r_sh[W-1:0];
    q_step    = {q_q[W-2:0], ge};
    cnt_step  = count_q - CW'(1);
    last_step = (count_q == '0);
`ifdef DIV_EARLY_EXIT_EN
    if (r_q == '0 && q_q[W-1 -: 8] == '0 && count_q >= CW'(7)) begin
      r_step    = '0;
      q_step    = {q_q[W-9:0], 8'h00};
      cnt_step  = count_q - CW'(8);
      last_step = (count_q == CW'(7));
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    q_d        = q_q;
    d_d        = d_q;
    count_d    = count_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    res_d      = res_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          d_d        = abs_val(op2, is_signed);
          q_d        = abs_val(op1, is_signed);
          r_d        = '0;
          count_d    = CW'(W - 1);
          neg_rem_d  = is_signed & op1[W-1];
          neg_quot_d = is_signed & (op1[W-1] ^ op2[W-1]);
          if (op2 == '0) begin
            res_d   = {op1, DIV0_QUOT};
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        r_d     = r_step;
        q_d     = q_step;
        count_d = cnt_step;
        if (last_step) begin
          res_d[RES_HI_LSB +: W] = neg_if(r_step, neg_rem_q);
          res_d[RES_LO_LSB +: W] = neg_if(q_step, neg_quot_q);
          state_d                = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      r_q        <= '0;
      q_q        <= '0;
      d_q        <= '0;
      count_q    <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      res_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      q_q        <= q_d;
      d_q        <= d_d;
      count_q    <= count_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      res_q      <= res_d;
      valid_q    <= valid_d;
    end
  end

  assign res  = res_q;
  assign hold = go & ~valid_q;

endmodule

// File: tb/tb_divider.sv
// Randomized and directed checks of divider against an arithmetic reference model.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op1, op2;
  logic        is_signed;
  logic        go;
  logic [63:0] res;
  logic        hold;

  int n_checks = 0;
  int n_errors = 0;
  int run_len  = 0;
  int max_run  = 0;

  divider dut (
    .clk       (clk),
    .rst       (rst),
    .op1       (op1),
    .op2       (op2),
    .is_signed (is_signed),
    .go        (go),
    .res       (res),
    .hold      (hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, lq, lr;
    logic [31:0] uq, ur;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      return {lr[31:0], lq[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  // Tracks how many consecutive cycles the requester sees an accept (go & ~hold).
  always begin
    @(negedge clk);
    #2;
    if (!rst && go && !hold) run_len++;
    else run_len = 0;
    if (run_len > max_run) max_run = run_len;
  end

  // Issues one divide; cycles counted are those with hold high, starting with the go cycle.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int exp_lat, input bit keep_go);
    int n;
    op1 = a;
    op2 = b;
    is_signed = s;
    go = 1'b1;
    #1;
    n = 0;
    while (hold === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
`ifdef DIV_EARLY_EXIT_EN
    if (b == 32'd0) check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    else check({tag, "_lat_le"}, 64'(n <= exp_lat && n > 0), 64'd1);
`else
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
`endif
    check({tag, "_res"}, res, model(a, b, s));
    if (!keep_go) go = 1'b0;
    @(negedge clk);
    #1;
    check({tag, "_gap_hold"}, 64'(hold), 64'(keep_go));
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    rst = 1'b1;
    go = 1'b0;
    op1 = '0;
    op2 = '0;
    is_signed = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_res", res, 64'd0);
    check("reset_hold", 64'(hold), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;

    do_div("divu_100_7", 32'd100, 32'd7, 1'b0, 33, 1'b0);
    check("divu_100_7_exact", res, {32'd2, 32'd14});
    do_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 1'b0);
    check("div_m7_2_exact", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 33, 1'b0);
    do_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 1'b0);
    check("div_ovf_exact", res, {32'h0, 32'h8000_0000});
    do_div("divu_5_0", 32'd5, 32'd0, 1'b0, 1, 1'b0);
    do_div("div_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 1, 1'b0);
    do_div("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 33, 1'b0);
    do_div("divu_0_9", 32'd0, 32'd9, 1'b0, 33, 1'b0);

    do_div("b2b_9_3", 32'd9, 32'd3, 1'b0, 33, 1'b1);
    do_div("b2b_10_3", 32'd10, 32'd3, 1'b0, 33, 1'b1);
    do_div("b2b_11_3", 32'd11, 32'd3, 1'b0, 33, 1'b0);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 15);
        2: b = -$urandom_range(1, 15);
        default: b = $urandom_range(0, 2);
      endcase
      if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 255);
      do_div("rand", a, b, s, (b == 32'd0) ? 1 : 33, 1'($urandom_range(0, 1)));
    end
    go = 1'b0;
    @(negedge clk);
    #1;

    op1 = 32'd100;
    op2 = 32'd7;
    is_signed = 1'b0;
    go = 1'b1;
    repeat (11) @(negedge clk);
    #1;
    rst = 1'b1;
    go = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_res", res, 64'd0);
    check("rst_mid_hold", 64'(hold), 64'd0);
    @(negedge clk);
    #1;
    do_div("after_rst_6_3", 32'd6, 32'd3, 1'b0, 33, 1'b0);
    check("after_rst_exact", res, {32'd0, 32'd2});

    check("single_accept", 64'(max_run), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
